raw_frame_reader: RTL and testbench

RAW_FRAME_READER -- requirements
Module: raw_frame_reader

---
 rtl/ether_pkg.sv | 21 ++
 rtl/raw_skid_buf.sv | 55 +++++
 rtl/raw_frame_reader.sv | 143 ++++++++++++++
 tb/tb_raw_frame_reader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ether_pkg.sv
// Shared definitions for the raw Ethernet frame path: FIFO entry layout,
// frame-length width and the frame reader state encoding.
package ether_pkg;

   localparam int RAW_W    = 9;
   localparam int LAST_BIT = 8;
   localparam int LEN_W    = 11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STREAM  = 2'd1,
      ST_DISCARD = 2'd2,
      ST_GAP     = 2'd3
   } rfr_state_e;

   // Skid slots still claimed after this cycle's pop, counting the read in flight.
   function automatic logic [2:0] slot_demand(input logic [1:0] occ, input logic pop, input logic infl);
      return {1'b0, occ} - {2'b00, pop} + {2'b00, infl};
   endfunction

endpackage

// File: rtl/raw_skid_buf.sv
// Two-entry skid buffer absorbing the one-cycle FIFO read latency.
// Entry 0 is always the head; clr empties it without touching the data.
module raw_skid_buf #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] wr_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   occ
);

   logic [W-1:0] ent0_r;
   logic [W-1:0] ent1_r;
   logic [1:0]   occ_r;

   // Entry storage and occupancy; the caller never pushes into a full buffer without popping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_r <= {W{1'b0}};
         ent1_r <= {W{1'b0}};
         occ_r  <= 2'd0;
      end else if (clr) begin
         occ_r <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ_r == 2'd0) ent0_r <= wr_data;
               else               ent1_r <= wr_data;
               occ_r <= occ_r + 2'd1;
            end
            2'b01: begin
               ent0_r <= ent1_r;
               occ_r  <= occ_r - 2'd1;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  ent0_r <= wr_data;
               end else begin
                  ent0_r <= ent1_r;
                  ent1_r <= wr_data;
               end
            end
            default: occ_r <= occ_r;
         endcase
      end
   end

   assign head = ent0_r;
   assign occ  = occ_r;

endmodule

// File: rtl/raw_frame_reader.sv
// Drains a 9-bit raw frame FIFO into a valid/ready byte stream, truncating
// oversize frames and enforcing an inter-frame gap.
module raw_frame_reader
   import ether_pkg::*;
#(
   parameter int IFG_CYCLES = 12,
   parameter int MAX_LEN    = 1518
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             fifo_re,
   input  logic [RAW_W-1:0] fifo_do,
   input  logic             fifo_empty,
   output logic [7:0]       m_data,
   output logic             m_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [LEN_W-1:0] frame_len,
   output logic             frame_done,
   output logic             trunc_err
);

   localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] TRUNC_IDX_C = LEN_W'(MAX_LEN - 1);
   localparam logic [15:0]      GAP_LAST_C  = 16'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);

   rfr_state_e       state_r;
   rfr_state_e       state_nx_s;
   logic             infl_r;
   logic             last_in_r;
   logic [LEN_W-1:0] byte_cnt_r;
   logic [15:0]      gap_r;
   logic [LEN_W-1:0] frame_len_r;
   logic             frame_done_r;
   logic             trunc_err_r;

   logic [RAW_W-1:0] head_s;
   logic [1:0]       occ_s;
   logic             arr_last_s;
   logic             stop_s;
   logic             m_valid_s;
   logic             m_last_s;
   logic             accept_s;
   logic             end_s;
   logic             trunc_s;
   logic             push_s;
   logic             clr_s;
   logic             re_s;

   raw_skid_buf #(.W(RAW_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr_s),
      .push    (push_s),
      .wr_data (fifo_do),
      .pop     (accept_s),
      .head    (head_s),
      .occ     (occ_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nx_s;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty) state_nx_s = ST_STREAM;
            else             state_nx_s = ST_IDLE;
         end
         ST_STREAM: begin
            if (trunc_s)    state_nx_s = ST_DISCARD;
            else if (end_s) state_nx_s = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            else            state_nx_s = ST_STREAM;
         end
         ST_DISCARD: begin
            if (stop_s) state_nx_s = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            else        state_nx_s = ST_DISCARD;
         end
         ST_GAP: begin
            if (gap_r == GAP_LAST_C) state_nx_s = ST_IDLE;
            else                     state_nx_s = ST_GAP;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // FSM outputs; once the last-flagged entry has arrived no read may touch the next frame.
   always_comb begin
      arr_last_s = infl_r & fifo_do[LAST_BIT];
      stop_s     = last_in_r | arr_last_s;
      m_valid_s  = (state_r == ST_STREAM) && (occ_s != 2'd0);
      m_last_s   = m_valid_s && (head_s[LAST_BIT] || (byte_cnt_r == TRUNC_IDX_C));
      accept_s   = m_valid_s && m_ready;
      end_s      = accept_s && m_last_s;
      trunc_s    = accept_s && !head_s[LAST_BIT] && (byte_cnt_r == TRUNC_IDX_C);
      push_s     = infl_r && (state_r == ST_STREAM);
      clr_s      = trunc_s || (state_r == ST_DISCARD);
      if (((state_r == ST_STREAM) || (state_r == ST_DISCARD)) && !fifo_empty && !stop_s &&
          (slot_demand(occ_s, accept_s, infl_r) < 3'd2)) begin
         re_s = 1'b1;
      end else begin
         re_s = 1'b0;
      end
   end

   // Read tracking, byte/gap counters and the registered status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         infl_r       <= 1'b0;
         last_in_r    <= 1'b0;
         byte_cnt_r   <= {LEN_W{1'b0}};
         gap_r        <= 16'd0;
         frame_len_r  <= {LEN_W{1'b0}};
         frame_done_r <= 1'b0;
         trunc_err_r  <= 1'b0;
      end else begin
         infl_r <= re_s;
         if (state_r == ST_IDLE) last_in_r <= 1'b0;
         else if (arr_last_s)    last_in_r <= 1'b1;
         if (state_r == ST_IDLE)                           byte_cnt_r <= {LEN_W{1'b0}};
         else if (accept_s && (byte_cnt_r != MAX_LEN_C))   byte_cnt_r <= byte_cnt_r + 11'd1;
         if (state_r != ST_GAP) gap_r <= 16'd0;
         else                   gap_r <= gap_r + 16'd1;
         if (end_s) frame_len_r <= byte_cnt_r + 11'd1;
         frame_done_r <= end_s;
         trunc_err_r  <= trunc_s;
      end
   end

   assign fifo_re    = re_s;
   assign m_data     = head_s[7:0];
   assign m_last     = m_last_s;
   assign m_valid    = m_valid_s;
   assign frame_len  = frame_len_r;
   assign frame_done = frame_done_r;
   assign trunc_err  = trunc_err_r;

endmodule

// File: tb/tb_raw_frame_reader.sv
// Directed bench for raw_frame_reader: one instance at default sizing, one with MAX_LEN=16.
module tb_raw_frame_reader;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // ---------------- instance A: default parameters ----------------
   logic       a_re, a_empty, a_last, a_valid, a_done, a_trunc;
   logic       a_ready = 1'b0;
   logic [8:0] a_do    = 9'h000;
   logic [7:0] a_data;
   logic [10:0] a_len;

   raw_frame_reader #(.IFG_CYCLES(12), .MAX_LEN(1518)) dut_a (
      .clk(clk), .rst_n(rst_n), .fifo_re(a_re), .fifo_do(a_do), .fifo_empty(a_empty),
      .m_data(a_data), .m_last(a_last), .m_valid(a_valid), .m_ready(a_ready),
      .frame_len(a_len), .frame_done(a_done), .trunc_err(a_trunc));

   logic [8:0] a_mem [0:1023];
   int         a_wp = 0, a_rp = 0;
   logic       a_hold = 1'b0, a_flush = 1'b0;
   assign a_empty = (a_rp == a_wp) || a_hold;

   always @(posedge clk) begin
      if (a_flush) a_rp <= a_wp;
      else if (a_re) begin
         a_do <= a_mem[a_rp];
         a_rp <= a_rp + 1;
      end
   end

   logic [8:0]  a_beats [0:1023];
   int          a_bcyc  [0:1023];
   logic [10:0] a_lens  [0:15];
   int a_nb = 0, a_nd = 0, a_stall_viol = 0, a_re_empty = 0, a_gap_re = 0, a_lowv = 0;
   int a_last_cyc = -100;
   logic a_pv = 1'b0, a_pr = 1'b0, a_pl = 1'b0;
   logic [7:0] a_pd = 8'h00;

   always @(negedge clk) begin
      if (rst_n) begin
         if (a_valid && a_ready) begin
            a_beats[a_nb] <= {a_last, a_data};
            a_bcyc[a_nb]  <= cyc;
            a_nb          <= a_nb + 1;
            if (a_last) a_last_cyc <= cyc;
         end
         if (a_done) begin
            a_lens[a_nd] <= a_len;
            a_nd         <= a_nd + 1;
         end
         if (a_re && a_empty) a_re_empty <= a_re_empty + 1;
         if (a_re && (cyc > a_last_cyc) && (cyc <= a_last_cyc + 12)) a_gap_re <= a_gap_re + 1;
         if (a_pv && !a_pr && !(a_valid && (a_data == a_pd) && (a_last == a_pl)))
            a_stall_viol <= a_stall_viol + 1;
         if (!a_valid) a_lowv <= a_lowv + 1;
         a_pv <= a_valid; a_pr <= a_ready; a_pd <= a_data; a_pl <= a_last;
      end else begin
         a_pv <= 1'b0;
      end
   end

   // ---------------- instance B: MAX_LEN = 16 ----------------
   logic       b_re, b_empty, b_last, b_valid, b_done, b_trunc;
   logic       b_ready = 1'b1;
   logic [8:0] b_do    = 9'h000;
   logic [7:0] b_data;
   logic [10:0] b_len;

   raw_frame_reader #(.IFG_CYCLES(12), .MAX_LEN(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .fifo_re(b_re), .fifo_do(b_do), .fifo_empty(b_empty),
      .m_data(b_data), .m_last(b_last), .m_valid(b_valid), .m_ready(b_ready),
      .frame_len(b_len), .frame_done(b_done), .trunc_err(b_trunc));

   logic [8:0] b_mem [0:63];
   int         b_wp = 0, b_rp = 0;
   assign b_empty = (b_rp == b_wp);

   always @(posedge clk) begin
      if (b_re) begin
         b_do <= b_mem[b_rp];
         b_rp <= b_rp + 1;
      end
   end

   logic [8:0]  b_beats [0:63];
   logic [10:0] b_lens  [0:7];
   int b_nb = 0, b_nd = 0, b_ntr = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (b_valid && b_ready) begin
            b_beats[b_nb] <= {b_last, b_data};
            b_nb          <= b_nb + 1;
         end
         if (b_done) begin
            b_lens[b_nd] <= b_len;
            b_nd         <= b_nd + 1;
         end
         if (b_trunc) b_ntr <= b_ntr + 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic load_a(input int n, input int base);
      for (int i = 0; i < n; i++) a_mem[a_wp + i] = {(i == n - 1), 8'(base + i)};
      a_wp = a_wp + n;
   endtask

   task automatic load_b(input int n, input int base);
      for (int i = 0; i < n; i++) b_mem[b_wp + i] = {(i == n - 1), 8'(base + i)};
      b_wp = b_wp + n;
   endtask

   function automatic int bad_a(input int start, input int n, input int base);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (a_beats[start + i] !== {(i == n - 1), 8'(base + i)}) bad++;
      return bad;
   endfunction

   task automatic wait_done_a(input string tag, input int target, input int limit);
      for (int i = 0; i < limit && a_nd < target; i++) @(posedge clk);
      check_eq(tag, a_nd, target);
   endtask

   task automatic check_outs_zero(input string tag);
      check_eq({tag, " fifo_re"},    a_re,    0);
      check_eq({tag, " m_valid"},    a_valid, 0);
      check_eq({tag, " m_last"},     a_last,  0);
      check_eq({tag, " m_data"},     a_data,  0);
      check_eq({tag, " frame_len"},  a_len,   0);
      check_eq({tag, " frame_done"}, a_done,  0);
      check_eq({tag, " trunc_err"},  a_trunc, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base, nb0, lowv0, bad;

      repeat (3) @(posedge clk);
      #1 check_outs_zero("reset");

      // 64-byte frame then a 4-byte frame, downstream always ready
      load_a(64, 8'h00);
      load_a(4, 8'h80);
      a_ready = 1'b1;
      rst_n   = 1'b1;
      wait_done_a("t1 frames done", 2, 400);
      check_eq("t1 beats", a_nb, 68);
      check_eq("t1 data", bad_a(0, 64, 8'h00) + bad_a(64, 4, 8'h80), 0);
      check_eq("t1 back-to-back span", a_bcyc[63] - a_bcyc[0], 63);
      check_eq("t1 len0", a_lens[0], 64);
      check_eq("t1 len1", a_lens[1], 4);
      check_eq("t1 gap >= ifg+1", (a_bcyc[64] - a_bcyc[63]) >= 13, 1);

      // same 64-byte frame with m_ready toggling every cycle
      repeat (20) @(posedge clk);
      base = a_nb;
      load_a(64, 8'h00);
      for (int i = 0; i < 600 && a_nd < 3; i++) begin
         @(posedge clk);
         #1 a_ready = ~a_ready;
      end
      check_eq("t2 frame done", a_nd, 3);
      a_ready = 1'b1;
      check_eq("t2 beats", a_nb - base, 64);
      check_eq("t2 data", bad_a(base, 64, 8'h00), 0);
      check_eq("t2 stall stability", a_stall_viol, 0);
      check_eq("t2 len", a_lens[2], 64);

      // truncation on the MAX_LEN=16 instance: 20-byte frame then 8-byte frame
      load_b(20, 8'h00);
      load_b(8, 8'h40);
      for (int i = 0; i < 400 && b_nd < 2; i++) @(posedge clk);
      check_eq("t3 frames done", b_nd, 2);
      check_eq("t3 beats", b_nb, 24);
      bad = 0;
      for (int i = 0; i < 16; i++) if (b_beats[i] !== {(i == 15), 8'(i)}) bad++;
      for (int i = 0; i < 8; i++) if (b_beats[16 + i] !== {(i == 7), 8'(8'h40 + i)}) bad++;
      check_eq("t3 data", bad, 0);
      check_eq("t3 trunc pulses", b_ntr, 1);
      check_eq("t3 len0", b_lens[0], 16);
      check_eq("t3 len1", b_lens[1], 8);
      check_eq("t3 fifo entries consumed", b_rp, 28);

      // two 1-byte frames back to back
      repeat (20) @(posedge clk);
      base = a_nb;
      load_a(1, 8'hA5);
      load_a(1, 8'h5A);
      wait_done_a("t4 frames done", 5, 200);
      check_eq("t4 beats", a_nb - base, 2);
      check_eq("t4 beat0", a_beats[base], 9'h1A5);
      check_eq("t4 beat1", a_beats[base + 1], 9'h15A);
      check_eq("t4 len0", a_lens[3], 1);
      check_eq("t4 len1", a_lens[4], 1);
      check_eq("t4 gap >= ifg+1", (a_bcyc[base + 1] - a_bcyc[base]) >= 13, 1);

      // FIFO reports empty for 5 cycles mid-frame
      repeat (20) @(posedge clk);
      base = a_nb;
      load_a(32, 8'h20);
      for (int i = 0; i < 200 && a_nb < base + 10; i++) @(posedge clk);
      check_eq("t5 reached mid-frame", a_nb >= base + 10, 1);
      #1 a_hold = 1'b1;
      lowv0 = a_lowv;
      nb0   = a_nb;
      repeat (5) @(posedge clk);
      #1 a_hold = 1'b0;
      check_eq("t5 m_valid dropped", (a_lowv - lowv0) > 0, 1);
      check_eq("t5 beats while empty <= 2", (a_nb - nb0) <= 2, 1);
      wait_done_a("t5 frame done", 6, 200);
      check_eq("t5 beats", a_nb - base, 32);
      check_eq("t5 data", bad_a(base, 32, 8'h20), 0);
      check_eq("t5 len", a_lens[5], 32);

      // reset pulsed at byte 10 of 64, then a clean 8-byte frame
      repeat (20) @(posedge clk);
      base = a_nb;
      load_a(64, 8'h00);
      for (int i = 0; i < 200 && a_nb < base + 10; i++) @(posedge clk);
      check_eq("t6 reached byte 10", a_nb >= base + 10, 1);
      #2 rst_n = 1'b0;
      #1 check_outs_zero("t6 mid-frame reset");
      a_flush = 1'b1;
      @(posedge clk);
      #1 a_flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_eq("t6 no frame_done for abandoned frame", a_nd, 6);
      base = a_nb;
      load_a(8, 8'h10);
      wait_done_a("t6 frame done", 7, 200);
      check_eq("t6 beats", a_nb - base, 8);
      check_eq("t6 data", bad_a(base, 8, 8'h10), 0);
      check_eq("t6 len", a_lens[6], 8);

      check_eq("no fifo_re while empty", a_re_empty, 0);
      check_eq("no fifo_re during ifg", a_gap_re, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
